// File: rtl/ram_access_ctrl_if.sv
// Core-side request/response bundle for ram_access_ctrl.
// The master modport is the load/store unit; the slave modport is the controller.
interface ram_access_ctrl_if #(
    parameter int RAM_WIDTH = 10
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_rw_len;
    logic [RAM_WIDTH:0]   req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_exception;

    modport master (
        output req_valid, req_rw_len, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_exception
    );

    modport slave (
        input  req_valid, req_rw_len, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_exception
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Byte/half/word load-store sequencer in front of a byte-wide RAM with registered read.
// Optional macro RAM_ACCESS_CTRL_ALIGN_CHECK_EN turns misaligned half/word requests into exceptions.
module ram_access_ctrl #(
    parameter int RAM_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_access_ctrl_if.slave     bus,
    output logic [RAM_WIDTH:0]   ram_addr,
    output logic                 ram_we,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]         state_reg;
    logic [1:0]         cnt_reg;
    logic [1:0]         last_reg;
    logic               write_reg;
    logic               exc_reg;
    logic [31:0]        wdata_reg;
    logic [RAM_WIDTH:0] ram_addr_reg;
    logic               ram_we_reg;
    logic [7:0]         ram_wdata_reg;
    logic [7:0]         data_byte [4];
    logic [31:0]        data_word;

    logic               accept;
    logic               req_exc;
    logic [1:0]         req_last;
    logic               cap_en;
    logic [1:0]         cap_idx;

    assign accept = (state_reg == IDLE) && bus.req_valid;

    always_comb begin
        req_exc = (bus.req_rw_len[1:0] == 2'b11);
`ifdef RAM_ACCESS_CTRL_ALIGN_CHECK_EN
        if (bus.req_rw_len[1:0] == 2'b01 && bus.req_addr[0] != 1'b0)
            req_exc = 1'b1;
        if (bus.req_rw_len[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
            req_exc = 1'b1;
`endif
    end

    always_comb begin
        case (bus.req_rw_len[1:0])
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 2'd0;
            last_reg      <= 2'd0;
            write_reg     <= 1'b0;
            exc_reg       <= 1'b0;
            wdata_reg     <= 32'd0;
            ram_addr_reg  <= '0;
            ram_we_reg    <= 1'b0;
            ram_wdata_reg <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_reg <= bus.req_rw_len[2];
                        last_reg  <= req_last;
                        cnt_reg   <= 2'd0;
                        exc_reg   <= req_exc;
                        if (req_exc) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg     <= ACCESS;
                            ram_addr_reg  <= bus.req_addr;
                            ram_we_reg    <= bus.req_rw_len[2];
                            ram_wdata_reg <= bus.req_wdata[7:0];
                            wdata_reg     <= {8'h00, bus.req_wdata[31:8]};
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_reg == last_reg) begin
                        ram_we_reg <= 1'b0;
                        state_reg  <= write_reg ? RESP : DRAIN;
                    end else begin
                        cnt_reg       <= cnt_reg + 2'd1;
                        ram_addr_reg  <= ram_addr_reg + (RAM_WIDTH + 1)'(1);
                        ram_wdata_reg <= wdata_reg[7:0];
                        wdata_reg     <= {8'h00, wdata_reg[31:8]};
                    end
                end
                DRAIN: state_reg <= RESP;
                RESP: begin
                    state_reg <= IDLE;
                    exc_reg   <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // RAM read data lags the address by one cycle, so byte k lands while the counter shows k+1
    // and the final byte arrives during DRAIN.
    assign cap_en  = (state_reg == DRAIN) ||
                     ((state_reg == ACCESS) && !write_reg && (cnt_reg != 2'd0));
    assign cap_idx = (state_reg == DRAIN) ? last_reg : (cnt_reg - 2'd1);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cap
            always_ff @(posedge clk) begin
                if (rst || accept)
                    data_byte[gi] <= 8'd0;
                else if (cap_en && cap_idx == 2'(gi))
                    data_byte[gi] <= ram_rdata;
            end
            assign data_word[8*gi +: 8] = data_byte[gi];
        end
    endgenerate

    assign bus.req_ready      = (state_reg == IDLE);
    assign bus.resp_valid     = (state_reg == RESP);
    assign bus.resp_rdata     = (state_reg == RESP) ? data_word : 32'd0;
    assign bus.resp_exception = (state_reg == RESP) && exc_reg;

    // Reset gates the strobe immediately so an aborted store writes nothing further.
    assign ram_we    = ram_we_reg && !rst;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
endmodule
